// File: rtl/fab_cfg_pkg.sv
// Shared types and constants for the fabric column configuration loader.
package fab_cfg_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, SETTLE, STROBE} state_t;

  localparam logic [15:0] SYNC = 16'hFAB0;

  localparam int ERR_SYNC  = 0;
  localparam int ERR_RANGE = 1;
  localparam int ERR_CHECK = 2;

endpackage

// File: rtl/frame_strobe_decoder.sv
// One-hot decode of a frame index onto the column's strobe lines.
// Indices at or above MaxFramesPerCol match no line, so they decode to all-zero.
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 20
) (
  input  logic [7:0]                 i_index,
  input  logic                       i_enable,
  output logic [MaxFramesPerCol-1:0] o_strobe
);

  generate
    for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_line
      assign o_strobe[gi] = i_enable && (i_index == 8'(gi));
    end
  endgenerate

endmodule

// File: rtl/frame_column_loader.sv
// Assembles one configuration frame per header and strobes it into a tile column.
// Define FRAME_CHECK_EN to require an XOR check word after the data words.
module frame_column_loader #(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 16
) (
  input  logic                                 UserCLK,
  input  logic                                 reset,
  input  logic [FrameBitsPerRow-1:0]           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [2:0]                           err,
  input  logic                                 err_clear
);

  import fab_cfg_pkg::*;

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [RowW-1:0] RowLast = RowW'(NumRows - 1);

  state_t                       r_state;
  logic [RowW-1:0]              r_row;
  logic [7:0]                   r_index;
  logic                         r_discard;
  logic [MaxFramesPerCol-1:0]   r_strobe;
  logic                         r_frame_done;
  logic [2:0]                   r_err;
  logic [FrameBitsPerRow-1:0]   r_rows [NumRows];

  logic                         w_hs;
  logic                         w_sync_ok;
  logic                         w_idx_oor;
  logic                         w_row_we;
  logic                         w_last_row;
  logic [2:0]                   w_set_err;
  logic [2:0]                   w_err_next;
  logic [MaxFramesPerCol-1:0]   w_strobe_dec;

`ifdef FRAME_CHECK_EN
  logic [FrameBitsPerRow-1:0]   r_xor;
  logic                         w_check_ok;
  assign w_check_ok = (s_data == r_xor);
`endif

  assign s_ready    = (r_state == IDLE) || (r_state == LOAD) || (r_state == CHECK);
  assign busy       = (r_state != IDLE);
  assign w_hs       = s_valid && s_ready;
  assign w_sync_ok  = (s_data[31:16] == SYNC);
  assign w_idx_oor  = (int'(s_data[7:0]) >= MaxFramesPerCol);
  assign w_last_row = (r_row == RowLast);
  assign w_row_we   = (r_state == LOAD) && w_hs && !r_discard;

  always_comb begin
    w_set_err = '0;
    if ((r_state == IDLE) && w_hs) begin
      w_set_err[ERR_SYNC]  = !w_sync_ok;
      w_set_err[ERR_RANGE] = w_sync_ok && w_idx_oor;
    end
`ifdef FRAME_CHECK_EN
    if ((r_state == CHECK) && w_hs)
      w_set_err[ERR_CHECK] = !w_check_ok;
`endif
  end

  // A new error event outranks a simultaneous clear.
  assign w_err_next = (err_clear ? 3'b000 : r_err) | w_set_err;

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_decoder (
    .i_index (r_index),
    .i_enable((r_state == SETTLE) && !r_discard),
    .o_strobe(w_strobe_dec)
  );

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_index      <= '0;
      r_discard    <= 1'b0;
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
      r_err        <= '0;
`ifdef FRAME_CHECK_EN
      r_xor        <= '0;
`endif
    end else begin
      r_strobe     <= '0;
      r_frame_done <= 1'b0;
      r_err        <= w_err_next;
      case (r_state)
        IDLE: begin
          if (w_hs && w_sync_ok) begin
            r_index   <= s_data[7:0];
            r_discard <= w_idx_oor;
            r_row     <= '0;
            r_state   <= LOAD;
`ifdef FRAME_CHECK_EN
            r_xor     <= s_data;
`endif
          end
        end
        LOAD: begin
          if (w_hs) begin
            r_row <= w_last_row ? '0 : r_row + 1'b1;
`ifdef FRAME_CHECK_EN
            r_xor <= r_xor ^ s_data;
            if (w_last_row) r_state <= CHECK;
`else
            if (w_last_row) r_state <= SETTLE;
`endif
          end
        end
`ifdef FRAME_CHECK_EN
        CHECK: begin
          if (w_hs) begin
            if (!w_check_ok) r_discard <= 1'b1;
            r_state <= SETTLE;
          end
        end
`endif
        SETTLE: begin
          // The strobe register loads here so it rises on entry to STROBE.
          r_strobe <= w_strobe_dec;
          if (r_discard) begin
            r_state      <= IDLE;
            r_frame_done <= 1'b1;
          end else begin
            r_state <= STROBE;
          end
        end
        STROBE: begin
          r_state      <= IDLE;
          r_frame_done <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRows; i++) r_rows[i] <= '0;
    end else if (w_row_we) begin
      r_rows[r_row] <= s_data;
    end
  end

  generate
    for (genvar gi = 0; gi < NumRows; gi++) begin : g_row_out
      assign FrameData[gi*FrameBitsPerRow +: FrameBitsPerRow] = r_rows[gi];
    end
  endgenerate

  assign FrameStrobe = r_strobe;
  assign frame_done  = r_frame_done;
  assign err         = r_err;

endmodule

// File: tb/tb_frame_column_loader.sv
// Directed bench for frame_column_loader: table of frames plus reset and check-word sequences.
// Honours FRAME_CHECK_EN the same way as the design.
module tb_frame_column_loader;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [511:0]  FrameData;
  logic [19:0]   FrameStrobe;
  logic          busy;
  logic          frame_done;
  logic [2:0]    err;
  logic          err_clear = 1'b0;

  frame_column_loader #(
    .MaxFramesPerCol(20),
    .FrameBitsPerRow(32),
    .NumRows(16)
  ) dut (
    .UserCLK    (clk),
    .reset      (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;

  int strobe_cnt = 0, strobe_cyc = 0, done_cnt = 0, done_cyc = 0, rl_cnt = 0, unstable = 0;
  logic [19:0]  strobe_val = '0;
  logic [511:0] prev_fd = '0;

  logic [31:0] exp_rows [16];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (FrameStrobe != '0) begin
      strobe_cnt = strobe_cnt + 1;
      strobe_val = FrameStrobe;
      strobe_cyc = cyc;
      if (FrameData !== prev_fd) unstable = unstable + 1;
    end
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (busy && !s_ready) rl_cnt = rl_cnt + 1;
    prev_fd = FrameData;
  end

  typedef struct {
    logic [31:0] hdr;
    logic [31:0] base;
    int          nwords;
    int          gap_row;
    logic        flip;
    logic        clr_chk;
    int          exp_strobes;
    logic [19:0] exp_strobe;
    logic [2:0]  exp_err;
    logic        exp_write;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic clr);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = w;
    err_clear = clr;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    hs_cyc = cyc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
  endtask

  task automatic check_rows(input string nm);
    for (int r = 0; r < 16; r++)
      chk(nm, FrameData[r*32 +: 32], exp_rows[r]);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int s0, d0, rl0, last;
    logic [31:0] cw;
    logic good;
    clear_err();
    s0 = strobe_cnt; d0 = done_cnt; rl0 = rl_cnt;
    good = (v.exp_strobes == 1);
    cw = v.hdr;
    send(v.hdr, 1'b0);
    for (int r = 0; r < v.nwords; r++) begin
      send(v.base + 32'(r), 1'b0);
      cw = cw ^ (v.base + 32'(r));
      if (r == v.gap_row) begin
        repeat (3) @(negedge clk);
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_no_strobe", 32'(strobe_cnt - s0), 32'd0);
      end
    end
`ifdef FRAME_CHECK_EN
    if (v.nwords > 0) send(cw ^ 32'(v.flip), v.clr_chk);
`endif
    last = hs_cyc;
    repeat (6) @(negedge clk);
    chk("strobe_count", 32'(strobe_cnt - s0), 32'(v.exp_strobes));
    if (good) begin
      chk("strobe_value", 32'(strobe_val), 32'(v.exp_strobe));
      chk("strobe_latency", 32'(strobe_cyc - last), 32'd2);
    end
    if (v.nwords > 0) begin
      chk("done_count", 32'(done_cnt - d0), 32'd1);
      chk("done_latency", 32'(done_cyc - last), good ? 32'd3 : 32'd2);
      chk("ready_low_cycles", 32'(rl_cnt - rl0), good ? 32'd2 : 32'd1);
    end else begin
      chk("done_count", 32'(done_cnt - d0), 32'd0);
    end
    chk("err", 32'(err), 32'(v.exp_err));
    chk("idle_ready", 32'(s_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    if (v.exp_write)
      for (int r = 0; r < 16; r++) exp_rows[r] = v.base + 32'(r);
    check_rows("frame_row");
    $display("vec %0d hdr %h strobes %0d err %b", id, v.hdr, strobe_cnt - s0, err);
  endtask

  vec_t vecs [6];

  initial begin
    vec_t v;
    int s0;
    vecs[0] = '{32'hFAB0_0005, 32'h1000_0000, 16, -1, 1'b0, 1'b0, 1, 20'h00020, 3'b000, 1'b1};
    vecs[1] = '{32'h1234_0003, 32'h0,          0, -1, 1'b0, 1'b0, 0, 20'h00000, 3'b001, 1'b0};
    vecs[2] = '{32'hFAB0_0000, 32'h2000_0000, 16,  7, 1'b0, 1'b0, 1, 20'h00001, 3'b000, 1'b1};
    vecs[3] = '{32'hFAB0_0014, 32'h3000_0000, 16, -1, 1'b0, 1'b0, 0, 20'h00000, 3'b010, 1'b0};
    vecs[4] = '{32'hFAB0_AB13, 32'h4000_0000, 16,  7, 1'b0, 1'b0, 1, 20'h80000, 3'b000, 1'b1};
    vecs[5] = '{32'hFAB0_00FF, 32'h5000_0000, 16, -1, 1'b0, 1'b0, 0, 20'h00000, 3'b010, 1'b0};
    for (int r = 0; r < 16; r++) exp_rows[r] = '0;

    repeat (3) @(negedge clk);
    chk("rst_strobe", 32'(FrameStrobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    check_rows("rst_row");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready_after_rst", 32'(s_ready), 32'd1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset during LOAD with rows 0..8 written.
    clear_err();
    s0 = strobe_cnt;
    send(32'hFAB0_0002, 1'b0);
    for (int r = 0; r < 9; r++) send(32'h6000_0000 + 32'(r), 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data_zero", 32'(FrameData == '0), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_strobe", 32'(FrameStrobe), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 16; r++) exp_rows[r] = '0;
    repeat (8) @(negedge clk);
    chk("midrst_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    $display("midrst sequence strobes %0d", strobe_cnt - s0);
    v = '{32'hFAB0_0003, 32'h7000_0000, 16, -1, 1'b0, 1'b0, 1, 20'h00008, 3'b000, 1'b1};
    run_vec(v, 6);

`ifdef FRAME_CHECK_EN
    // Flipped check word with err_clear on the same handshake.
    v = '{32'hFAB0_0004, 32'h8000_0000, 16, -1, 1'b1, 1'b1, 0, 20'h00000, 3'b100, 1'b1};
    run_vec(v, 7);
    v = '{32'hFAB0_0009, 32'h9000_0000, 16, -1, 1'b0, 1'b0, 1, 20'h00200, 3'b000, 1'b1};
    run_vec(v, 8);
`endif

    chk("data_stable_under_strobe", 32'(unstable), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got %0d want 0", cyc);
    $fatal(1, "timeout");
  end

endmodule
